// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Purpose  : Lets the IF stage (fetch) and the MEM stage (load/store) share |
// |            one single-ported, variable-latency memory. Data accesses win |
// |            because they belong to the older instruction. proc_stall holds |
// |            the pipeline until both requesters have been served, and a     |
// |            watchdog aborts accesses that the memory never acknowledges.   |
// | Ports    : clk, rst_n          - clock, async active-low reset            |
// |            i_req/i_addr        - fetch request and word address          |
// |            i_rdata/i_valid     - fetched word, one-cycle valid pulse      |
// |            d_read/d_write      - load / store request                     |
// |            d_addr/d_wdata      - data word address and store data         |
// |            d_rdata/d_valid     - load data, completion pulse              |
// |            mem_*               - registered memory strobes, addr, wdata;  |
// |                                  mem_rdata/mem_ready from memory          |
// |            proc_stall          - combinational pipeline freeze            |
// |            timeout_err         - sticky watchdog-abort flag               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_W  = 30,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_valid,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_valid,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              proc_stall,
   output logic              timeout_err
);

   localparam int c_CNT_W = $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_d_done;
   logic                r_i_done;
   logic [c_CNT_W-1:0]  r_wait_cnt;
   logic [31:0]         r_i_rdata;
   logic                r_i_valid;
   logic [31:0]         r_d_rdata;
   logic                r_d_valid;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_timeout_err;

   logic                w_d_need;
   logic                w_i_need;
   logic                w_stall;
   logic                w_timeout;
   logic                w_complete;
   logic [31:0]         w_rdata_eff;

   assign w_d_need    = (d_read | d_write) & ~r_d_done;
   assign w_i_need    = i_req & ~r_i_done;
   assign w_stall     = w_d_need | w_i_need;

   // The watchdog completes the access in its last allowed cycle, so an
   // aborted access behaves exactly like an acknowledged one returning zero.
   assign w_timeout   = (r_state != IDLE) && !mem_ready && (r_wait_cnt == c_CNT_MAX);
   assign w_complete  = (r_state != IDLE) && (mem_ready || w_timeout);
   assign w_rdata_eff = w_timeout ? 32'd0 : mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_d_need) begin
               w_state_nxt = D_WAIT;
            end else if (w_i_need) begin
               w_state_nxt = I_WAIT;
            end
         end
         D_WAIT: begin
            // A fetch waiting behind the data access follows back-to-back.
            if (w_complete) begin
               w_state_nxt = w_i_need ? I_WAIT : IDLE;
            end
         end
         I_WAIT: begin
            if (w_complete) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_done      <= 1'b0;
         r_i_done      <= 1'b0;
         r_wait_cnt    <= '0;
         r_i_rdata     <= '0;
         r_i_valid     <= 1'b0;
         r_d_rdata     <= '0;
         r_d_valid     <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_i_valid <= 1'b0;
         r_d_valid <= 1'b0;

         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end

         // Counter restarts on every entry into a wait state.
         if ((w_state_nxt != IDLE) && ((r_state == IDLE) || w_complete)) begin
            r_wait_cnt <= '0;
         end else if (r_state != IDLE) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end

         if ((r_state == IDLE) && (w_state_nxt == D_WAIT)) begin
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_read  <= d_read;
            r_mem_write <= d_write;
         end else if ((r_state != I_WAIT) && (w_state_nxt == I_WAIT)) begin
            r_mem_addr  <= i_addr;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
         end else if (w_state_nxt == IDLE) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
         end

         if (w_complete && (r_state == D_WAIT)) begin
            if (r_mem_read) begin
               r_d_rdata <= w_rdata_eff;
            end
            r_d_valid <= 1'b1;
         end
         if (w_complete && (r_state == I_WAIT)) begin
            r_i_rdata <= w_rdata_eff;
            r_i_valid <= 1'b1;
         end

         // Pipeline advancing clears both flags; this takes precedence so a
         // request dropped mid-access cannot leave a stale done flag behind.
         if (!w_stall) begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
         end else begin
            if (w_complete && (r_state == D_WAIT)) begin
               r_d_done <= 1'b1;
            end
            if (w_complete && (r_state == I_WAIT)) begin
               r_i_done <= 1'b1;
            end
         end
      end
   end

   assign i_rdata     = r_i_rdata;
   assign i_valid     = r_i_valid;
   assign d_rdata     = r_d_rdata;
   assign d_valid     = r_d_valid;
   assign mem_read    = r_mem_read;
   assign mem_write   = r_mem_write;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign proc_stall  = w_stall;
   assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
